// File: rtl/gates_pkg.sv
// gates_pkg: shared FSM state type and truth-table constants for the gate library.
// Truth tables are indexed by {a,b}: bit i is the expected y for input vector i.
package gates_pkg;

    typedef enum logic [1:0] {
        TT_IDLE   = 2'd0,
        TT_SETTLE = 2'd1,
        TT_SAMPLE = 2'd2,
        TT_DONE   = 2'd3
    } tt_state_t;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/gate_tt_sequencer.sv
// gate_tt_sequencer: drives vectors 00,01,10,11 onto a 2-input gate and checks y against EXPECTED.
// Ports: clk/rst (sync, active-high); start begins a run from IDLE; y_in is the gate output;
// a_out/b_out drive the gate; busy covers SETTLE/SAMPLE; done pulses once per run;
// pass/fail_mask hold the last run's result; vec_idx is the vector currently applied.
module gate_tt_sequencer
    import gates_pkg::*;
#(
    parameter logic [3:0] EXPECTED      = TT_XNOR,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [1:0] vec_idx
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    tt_state_t     state_q, state_d;
    logic [1:0]    vec_idx_q, vec_idx_d;
    logic [CW-1:0] settle_cnt_q, settle_cnt_d;
    logic [3:0]    fail_mask_q, fail_mask_d;
    logic          pass_q, pass_d;

    always_comb begin
        state_d      = state_q;
        vec_idx_d    = vec_idx_q;
        settle_cnt_d = settle_cnt_q;
        fail_mask_d  = fail_mask_q;
        pass_d       = pass_q;
        case (state_q)
            TT_IDLE: begin
                if (start) begin
                    state_d      = TT_SETTLE;
                    vec_idx_d    = 2'd0;
                    settle_cnt_d = '0;
                    fail_mask_d  = 4'd0;
                    pass_d       = 1'b0;
                end
            end
            TT_SETTLE: begin
                settle_cnt_d = settle_cnt_q + CW'(1);
                if (settle_cnt_q == CNT_LAST) state_d = TT_SAMPLE;
            end
            TT_SAMPLE: begin
                fail_mask_d[vec_idx_q] = y_in != EXPECTED[vec_idx_q];
                if (vec_idx_q == 2'd3) begin
                    // pass is latched here so it already reflects the final sample in the done cycle
                    state_d = TT_DONE;
                    pass_d  = fail_mask_d == 4'd0;
                end else begin
                    state_d      = TT_SETTLE;
                    vec_idx_d    = vec_idx_q + 2'd1;
                    settle_cnt_d = '0;
                end
            end
            TT_DONE: begin
                state_d   = TT_IDLE;
                vec_idx_d = 2'd0;
            end
            default: state_d = TT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= TT_IDLE;
            vec_idx_q    <= 2'd0;
            settle_cnt_q <= '0;
            fail_mask_q  <= 4'd0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_idx_q    <= vec_idx_d;
            settle_cnt_q <= settle_cnt_d;
            fail_mask_q  <= fail_mask_d;
            pass_q       <= pass_d;
        end
    end

    assign a_out     = vec_idx_q[1];
    assign b_out     = vec_idx_q[0];
    assign vec_idx   = vec_idx_q;
    assign busy      = state_q == TT_SETTLE || state_q == TT_SAMPLE;
    assign done      = state_q == TT_DONE;
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: doc/gate_tt_sequencer.md
# gate_tt_sequencer

Self-checking truth-table sequencer for a 2-input combinational gate unit (`gates`: inputs `a`, `b`, output `y`). On `start` it drives the four input vectors 00, 01, 10, 11 onto the gate. After a programmable settle time it samples `y` for each vector, compares it against an expected truth table, and reports a per-vector fail mask plus an overall pass flag. It lets the gate library be exercised in hardware, on-chip or on the FPGA bench, without a simulator-side stimulus process.

## Interface
- `EXPECTED`, default 4'b1001 (XNOR): expected `y` per vector; bit index = {a,b}.
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range ≥ 1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE.
- `y_in`  in  1  gate output `y`.
- `a_out`  out  1  gate input `a`.
- `b_out`  out  1  gate input `b`.
- `busy`  out  1  high from the first cycle after accepted start through the last SAMPLE.
- `done`  out  1  single-cycle pulse at end of run.
- `pass`  out  1  1 when the last completed run had no mismatches; held until next accepted start.
- `fail_mask`  out  4  bit i set when vector i mismatched; held until next accepted start.
- `vec_idx`  out  2  current vector; {a_out,b_out} == vec_idx.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - busy=0; vec_idx holds 0.
  - start=1 → vec_idx←0, fail_mask←0, pass←0, settle_cnt←0, go to SETTLE.
- SETTLE:
  - busy=1; settle_cnt increments each cycle.
  - When settle_cnt == SETTLE_CYCLES-1 → SAMPLE.
- SAMPLE:
  - busy=1; fail_mask[vec_idx] ← (y_in != EXPECTED[vec_idx]).
  - vec_idx==3 → DONE.
  - Otherwise vec_idx←vec_idx+1, settle_cnt←0, go to SETTLE.
- DONE:
  - done=1, busy=0; pass ← (updated fail_mask == 0), computed including the final sample's result.
  - Unconditionally go to IDLE next cycle.
- start outside IDLE is ignored; no queuing.
- start held continuously: a new run is accepted in the IDLE cycle following DONE.
- vec_idx wraps only via return to IDLE; it never increments past 3.
- settle_cnt width is $clog2(SETTLE_CYCLES+1); SETTLE_CYCLES=1 gives exactly one SETTLE cycle per vector.
- Reset values:
  - state=IDLE; vec_idx=0, so a_out=b_out=0.
  - busy=0, done=0, pass=0, fail_mask=0, settle_cnt=0.
- Reset mid-run: all of the above on the next edge; the partial result is discarded and pass stays 0.

## Timing
- All outputs registered or decoded from registered state; no combinational path from y_in to any output.
- a_out/b_out change on the edge entering SETTLE. The gate is combinational, so y_in is valid by SAMPLE for any SETTLE_CYCLES ≥ 1; a larger value covers a registered gate.
- Per vector: SETTLE_CYCLES + 1 cycles.
- Run length:
  - start accepted at edge E → busy high from E+1 through E+4·(SETTLE_CYCLES+1).
  - done high for exactly the following cycle.
  - With the default of 2: busy for 12 cycles, done in cycle 13.
- pass and fail_mask are stable from the done cycle until the cycle after the next accepted start.

## Structure
- Shared package `gates_pkg`:
  - FSM state enum `tt_state_t`.
  - Truth-table constants for the gate library: AND=4'b1000, OR=4'b1110, XOR=4'b0110, XNOR=4'b1001, NAND=4'b0111, NOR=4'b0001.
  - The parameter default references `gates_pkg` XNOR.
- Single module, no sub-modules; the settle counter is inline.
- Top-level wrapper instantiates `gates` with a_out→a, b_out→b, y→y_in.

## Test plan
- XNOR gate, defaults, start pulse at cycle 5 → a/b sequence 00,01,10,11, each held 3 cycles; done in cycle 18; pass=1, fail_mask=4'b0000.
- y_in stuck at 0, EXPECTED=4'b1001 → fail_mask=4'b1001, pass=0, done timing unchanged.
- AND gate with EXPECTED=4'b1001 → fail_mask=4'b0001 (vector 00 mismatches), pass=0.
- start re-pulsed during run and SETTLE_CYCLES=1 → re-pulse ignored; busy exactly 8 cycles; single done pulse.
- rst asserted during SETTLE of vector 2 → next cycle: IDLE, a_out=b_out=0, busy=0, fail_mask=0, pass=0, no done pulse. Fresh start afterwards completes normally with pass=1.
- start held high for 40 cycles (defaults) → back-to-back runs separated by one IDLE cycle; done pulses 14 cycles apart.
